// File: rtl/cpu_pkg.sv
// Shared CPU constants and the IF/ID update-kind encoding.
// Every pipeline stage imports this package.
package cpu_pkg;

   localparam int                DATA_W    = 32;
   localparam logic [DATA_W-1:0] NOP_INSTR = '0;   // sll $0,$0,0
   localparam int                PC_INCR   = 4;

   typedef enum logic [1:0] {
      UPD_RESET  = 2'd0,
      UPD_BUBBLE = 2'd1,
      UPD_HOLD   = 2'd2,
      UPD_LOAD   = 2'd3
   } upd_e;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// A synchronous clear takes priority over increment.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] cnt_o
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures PC, PC+4 and the fetched instruction,
// holds on load-use stall, loads a NOP bubble on flush or while idle.
module if_id_reg
   import cpu_pkg::*;
#(
   parameter int                DATA_W = cpu_pkg::DATA_W,
   parameter int                CNT_W  = 16,
   parameter logic [DATA_W-1:0] NOP    = NOP_INSTR
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic [DATA_W-1:0] pc_i,
   input  logic [DATA_W-1:0] instr_i,
   output logic [DATA_W-1:0] pc_o,
   output logic [DATA_W-1:0] pc_plus4_o,
   output logic [DATA_W-1:0] instr_o,
   output logic              valid_o,
   output logic [CNT_W-1:0]  stall_cnt_o,
   output logic [CNT_W-1:0]  flush_cnt_o
);

   // valid_o=1 means instr_o/pc_o/pc_plus4_o describe a real fetched
   // instruction; there is no back-pressure, the next stage accepts every cycle.
   upd_e              upd;
   logic [DATA_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] pc4_q, pc4_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic              valid_q, valid_d;
   logic              stall_inc;
   logic              flush_inc;

   always_comb begin
      if (rst_i) begin
         upd = UPD_RESET;
      end else if (!start_i || flush_i) begin
         upd = UPD_BUBBLE;
      end else if (stall_i) begin
         upd = UPD_HOLD;
      end else begin
         upd = UPD_LOAD;
      end
   end

   assign stall_inc = (upd == UPD_HOLD);
   assign flush_inc = !rst_i && start_i && flush_i;

   always_comb begin
      pc_d    = pc_q;
      pc4_d   = pc4_q;
      instr_d = instr_q;
      valid_d = valid_q;
      unique case (upd)
         UPD_RESET: begin
            pc_d    = '0;
            pc4_d   = '0;
            instr_d = NOP;
            valid_d = 1'b0;
         end
         // A bubble keeps the PC fields so branch logic never sees garbage.
         UPD_BUBBLE: begin
            instr_d = NOP;
            valid_d = 1'b0;
         end
         UPD_HOLD: ;
         UPD_LOAD: begin
            pc_d    = pc_i;
            pc4_d   = pc_i + DATA_W'(PC_INCR);
            instr_d = instr_i;
            valid_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
   end

   sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .clk_i (clk_i),
      .clr_i (rst_i),
      .inc_i (stall_inc),
      .cnt_o (stall_cnt_o)
   );

   sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
      .clk_i (clk_i),
      .clr_i (rst_i),
      .inc_i (flush_inc),
      .cnt_o (flush_cnt_o)
   );

   assign pc_o       = pc_q;
   assign pc_plus4_o = pc4_q;
   assign instr_o    = instr_q;
   assign valid_o    = valid_q;

endmodule
